bcd_counter_n: RTL and testbench
================================

Name: bcd_counter_n

Overview:
- Parametrised N-digit cascaded decade counter for the digital frequency meter; next generation of the single-digit decade counter.
- Counts rising edges of `fin` while `en_in` is high. All digits carry within one cycle, with no ripple between instances.
- Provides a snapshot register that the gate controller loads at the end of each gate window, a registered carry-out for cascading, and a sticky overflow flag.

Parameters:
- DIGITS, 4, number of 4-bit digits (1..8); digit 0 is least significant.
- DIGIT_MAX, 9, terminal value of each digit (1..15); 9 gives BCD, 15 gives hex.

Ports:
- fin  input  1  counted signal, used as the clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- en_in  input  1  count enable; one increment per `fin` edge while high.
- clear  input  1  synchronous clear of the running count and `ovf`.
- latch  input  1  snapshot request; captures the running count into `q_latched`.
- q  output  4*DIGITS  running count, digit k at bits [4k+3:4k].
- en_out  output  1  registered carry-out, for cascading further instances.
- ovf  output  1  sticky overflow of the running count.
- q_latched  output  4*DIGITS  snapshot of `q`.
- ovf_latched  output  1  snapshot of `ovf`.
- latch_valid  output  1  one-cycle pulse after a snapshot.

Behaviour:
- Single clock domain (`fin`). All outputs are registers; no combinational path from input to output.

Reset:
- Reset is synchronous and active-low: `rst_n` is sampled on the `fin` rising edge.
- Reset has highest priority.
- Reset values: `q`=0, `en_out`=0, `ovf`=0, `q_latched`=0, `ovf_latched`=0, `latch_valid`=0.
- Reset asserted mid-count or mid-latch discards all state; nothing is captured.

Priority for the running count when not in reset: `clear` > `en_in` > hold.
- `clear`=1: `q`<=0, `ovf`<=0, `en_out`<=0, regardless of `en_in`.
- `en_in`=1, `clear`=0:
  - digit k increments iff digits 0..k-1 all equal DIGIT_MAX (digit 0 always increments);
  - a digit at DIGIT_MAX that increments wraps to 0;
  - all carries resolve in the same cycle.
- Terminal state (all digits = DIGIT_MAX) with `en_in`=1:
  - `q` wraps to all zeros;
  - `en_out`<=1 for exactly that one cycle;
  - `ovf`<=1, and stays set until `clear` or reset.
- In every other cycle `en_out`<=0. Hold keeps `q` and `ovf`.
- Digit values above DIGIT_MAX are unreachable. If one appears, the next increment forces that digit to 0 with no carry.

Snapshot:
- `latch`=1 loads `q_latched`<=`q` and `ovf_latched`<=`ovf`. The values captured are those before the same edge's update.
- `latch` together with `clear` in one cycle: the pre-clear count is captured and the counter then clears. This is the normal end-of-gate sequence.
- `latch` together with an increment: the pre-increment value is captured.
- `latch_valid`<=`latch`, so the pulse appears one cycle after the edge on which `latch` is sampled.
- Back-to-back `latch` gives one `latch_valid` per `latch` cycle.
- `q_latched` and `ovf_latched` hold between snapshots. `clear` does not affect them.

Latency:
- Increment to `q`: 1 cycle.
- `latch` to `q_latched`: 1 cycle.
- Terminal increment to `en_out`: 1 cycle.

Optional Feature:
- Macro: BCD_COUNTER_SATURATE_EN.
- Defined:
  - at the terminal state with `en_in`=1, `q` holds at all DIGIT_MAX instead of wrapping;
  - `ovf`<=1 as normal;
  - `en_out` stays 0 at all times;
  - `clear` and reset restore 0 as normal.
- Undefined: wrap-around behaviour as specified above.

Test Plan:
- Reset: `rst_n`=0 for 2 edges with `en_in`=1 -> all outputs 0. Release with `en_in`=1 for 3 edges -> `q`=16'h0003.
- Carry chain (DIGITS=4): preload by counting to 16'h0999, one more enabled edge -> `q`=16'h1000 next cycle, `en_out`=0, `ovf`=0.
- Wrap: count to 16'h9999, one more enabled edge -> `q`=16'h0000, `en_out`=1 for 1 cycle, `ovf`=1 sticky until `clear`. With BCD_COUNTER_SATURATE_EN defined -> `q`=16'h9999, `en_out`=0, `ovf`=1.
- Gate end: `q`=16'h0427, assert `latch`+`clear`+`en_in` on one edge -> `q_latched`=16'h0427, `q`=0, `latch_valid`=1 on the following cycle only.
- Priority: `en_in`=1 and `clear`=1 held 3 edges -> `q` stays 0. Drop `en_in` with `clear`=0 -> `q` holds value.
- Hex mode (DIGIT_MAX=15, DIGITS=2): 256 enabled edges from 0 -> `q`=8'h00, single `en_out` pulse, `ovf`=1.

Source files
------------

// File: rtl/bcd_counter_n.sv
// Parametrised N-digit cascaded decade/hex counter with snapshot register and sticky overflow.
// Define BCD_COUNTER_SATURATE_EN to hold at the terminal count instead of wrapping.
module bcd_counter_n #(
    parameter int DIGITS    = 4,
    parameter int DIGIT_MAX = 9
) (
    input  logic                  fin,
    input  logic                  rst_n,
    input  logic                  en_in,
    input  logic                  clear,
    input  logic                  latch,
    output logic [4*DIGITS-1:0]   q,
    output logic                  en_out,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   q_latched,
    output logic                  ovf_latched,
    output logic                  latch_valid
);

    localparam int         W    = 4 * DIGITS;
    localparam logic [3:0] MAXV = 4'(DIGIT_MAX);

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_COUNT
    } op_e;

    logic [W-1:0] count_q, count_d;
    logic [W-1:0] incr;
    logic         ovf_q, ovf_d;
    logic         en_out_q, en_out_d;
    logic [W-1:0] q_latched_q, q_latched_d;
    logic         ovf_latched_q, ovf_latched_d;
    logic         latch_valid_q, latch_valid_d;
    logic         terminal;
    logic         carry;
    op_e          op;

    // Whole carry chain resolves in one pass; an out-of-range digit is forced to 0 and stops the carry.
    always_comb begin
        incr     = count_q;
        terminal = 1'b1;
        carry    = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (count_q[4*k +: 4] != MAXV) begin
                terminal = 1'b0;
            end
            if (carry) begin
                if (count_q[4*k +: 4] == MAXV) begin
                    incr[4*k +: 4] = 4'd0;
                end else if (count_q[4*k +: 4] > MAXV) begin
                    incr[4*k +: 4] = 4'd0;
                    carry          = 1'b0;
                end else begin
                    incr[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                    carry          = 1'b0;
                end
            end
        end
    end

    always_comb begin
        op = OP_HOLD;
        if (clear) begin
            op = OP_CLEAR;
        end else if (en_in) begin
            op = OP_COUNT;
        end
    end

    always_comb begin
        count_d  = count_q;
        ovf_d    = ovf_q;
        en_out_d = 1'b0;
        case (op)
            OP_CLEAR: begin
                count_d = '0;
                ovf_d   = 1'b0;
            end
            OP_COUNT: begin
                if (terminal) begin
                    ovf_d = 1'b1;
`ifdef BCD_COUNTER_SATURATE_EN
                    count_d  = count_q;
                    en_out_d = 1'b0;
`else
                    count_d  = '0;
                    en_out_d = 1'b1;
`endif
                end else begin
                    count_d = incr;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Snapshot captures the values from before this edge's count update.
    always_comb begin
        q_latched_d   = q_latched_q;
        ovf_latched_d = ovf_latched_q;
        latch_valid_d = latch;
        if (latch) begin
            q_latched_d   = count_q;
            ovf_latched_d = ovf_q;
        end
    end

    always_ff @(posedge fin) begin
        if (!rst_n) begin
            count_q       <= '0;
            ovf_q         <= 1'b0;
            en_out_q      <= 1'b0;
            q_latched_q   <= '0;
            ovf_latched_q <= 1'b0;
            latch_valid_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            ovf_q         <= ovf_d;
            en_out_q      <= en_out_d;
            q_latched_q   <= q_latched_d;
            ovf_latched_q <= ovf_latched_d;
            latch_valid_q <= latch_valid_d;
        end
    end

    assign q           = count_q;
    assign en_out      = en_out_q;
    assign ovf         = ovf_q;
    assign q_latched   = q_latched_q;
    assign ovf_latched = ovf_latched_q;
    assign latch_valid = latch_valid_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: a 4-digit BCD instance and a 2-digit hex instance share stimulus
// and are checked every cycle against an integer-arithmetic reference model.
module tb_bcd_counter_n;

    logic        fin = 1'b0;
    logic        rst_n, en_in, clear, latch;
    logic [15:0] qB, qlB;
    logic        enB, ovfB, ovflB, lvB;
    logic [7:0]  qH, qlH;
    logic        enH, ovfH, ovflH, lvH;

    int nChecks = 0;
    int nFails  = 0;

    // Index 0 is the BCD instance, index 1 the hex instance.
    int mBase [2] = '{10, 16};
    int mDig  [2] = '{4, 2};
    int mMod  [2] = '{10000, 256};
    int mCnt  [2];
    int mQl   [2];
    bit mOvf  [2];
    bit mEo   [2];
    bit mOvfL [2];
    bit mLv   [2];

    bcd_counter_n #(.DIGITS(4), .DIGIT_MAX(9)) dutB (
        .fin(fin), .rst_n(rst_n), .en_in(en_in), .clear(clear), .latch(latch),
        .q(qB), .en_out(enB), .ovf(ovfB), .q_latched(qlB),
        .ovf_latched(ovflB), .latch_valid(lvB)
    );

    bcd_counter_n #(.DIGITS(2), .DIGIT_MAX(15)) dutH (
        .fin(fin), .rst_n(rst_n), .en_in(en_in), .clear(clear), .latch(latch),
        .q(qH), .en_out(enH), .ovf(ovfH), .q_latched(qlH),
        .ovf_latched(ovflH), .latch_valid(lvH)
    );

    always #5 fin = ~fin;

    function automatic logic [31:0] toVec(input int base, input int digits, input int value);
        logic [31:0] v;
        int          rem;
        v   = '0;
        rem = value;
        for (int k = 0; k < digits; k++) begin
            v[4*k +: 4] = 4'(rem % base);
            rem         = rem / base;
        end
        return v;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: the count is a plain integer modulo base**digits.
    task automatic modelUpdate();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mCnt[i] = 0; mQl[i] = 0; mOvf[i] = 0; mEo[i] = 0; mOvfL[i] = 0; mLv[i] = 0;
            end else begin
                mLv[i] = latch;
                if (latch) begin
                    mQl[i]   = mCnt[i];
                    mOvfL[i] = mOvf[i];
                end
                mEo[i] = 1'b0;
                if (clear) begin
                    mCnt[i] = 0;
                    mOvf[i] = 1'b0;
                end else if (en_in) begin
                    if (mCnt[i] == mMod[i] - 1) begin
                        mOvf[i] = 1'b1;
`ifndef BCD_COUNTER_SATURATE_EN
                        mCnt[i] = 0;
                        mEo[i]  = 1'b1;
`endif
                    end else begin
                        mCnt[i] = mCnt[i] + 1;
                    end
                end
            end
        end
    endtask

    task automatic checkOutput();
        checkVal("B.q",           {16'b0, qB},  toVec(10, 4, mCnt[0]));
        checkVal("B.en_out",      {31'b0, enB}, {31'b0, mEo[0]});
        checkVal("B.ovf",         {31'b0, ovfB}, {31'b0, mOvf[0]});
        checkVal("B.q_latched",   {16'b0, qlB}, toVec(10, 4, mQl[0]));
        checkVal("B.ovf_latched", {31'b0, ovflB}, {31'b0, mOvfL[0]});
        checkVal("B.latch_valid", {31'b0, lvB}, {31'b0, mLv[0]});
        checkVal("H.q",           {24'b0, qH},  toVec(16, 2, mCnt[1]));
        checkVal("H.en_out",      {31'b0, enH}, {31'b0, mEo[1]});
        checkVal("H.ovf",         {31'b0, ovfH}, {31'b0, mOvf[1]});
        checkVal("H.q_latched",   {24'b0, qlH}, toVec(16, 2, mQl[1]));
        checkVal("H.ovf_latched", {31'b0, ovflH}, {31'b0, mOvfL[1]});
        checkVal("H.latch_valid", {31'b0, lvH}, {31'b0, mLv[1]});
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic c, input logic l);
        rst_n = r; en_in = e; clear = c; latch = l;
        @(posedge fin);
        modelUpdate();
        #1;
        checkOutput();
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; en_in = 1'b1; clear = 1'b0; latch = 1'b0;
        #2;

        // Reset with enable high, then release and count three edges.
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkVal("reset.q", {16'b0, qB}, 32'h0);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkVal("release.q", {16'b0, qB}, 32'h0003);

        // Carry across three digits at once.
        repeat (996) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkVal("pre_carry.q", {16'b0, qB}, 32'h0999);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkVal("carry.q", {16'b0, qB}, 32'h1000);
        checkVal("carry.en_out", {31'b0, enB}, 32'h0);

        // Terminal count.
        repeat (8999) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkVal("pre_wrap.q", {16'b0, qB}, 32'h9999);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef BCD_COUNTER_SATURATE_EN
        checkVal("wrap.q", {16'b0, qB}, 32'h9999);
        checkVal("wrap.en_out", {31'b0, enB}, 32'h0);
`else
        checkVal("wrap.q", {16'b0, qB}, 32'h0000);
        checkVal("wrap.en_out", {31'b0, enB}, 32'h1);
`endif
        checkVal("wrap.ovf", {31'b0, ovfB}, 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("sticky.ovf", {31'b0, ovfB}, 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkVal("cleared.ovf", {31'b0, ovfB}, 32'h0);

        // End-of-gate: latch, clear and enable together.
        repeat (427) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkVal("gate.q_latched", {16'b0, qlB}, 32'h0427);
        checkVal("gate.q", {16'b0, qB}, 32'h0);
        checkVal("gate.latch_valid", {31'b0, lvB}, 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("gate.latch_valid_drop", {31'b0, lvB}, 32'h0);

        // Clear beats enable; hold keeps the count.
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("hold.q", {16'b0, qB}, 32'h0005);

        // Hex instance: a full 256-edge revolution from zero.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            if (enH) pulses++;
        end
`ifdef BCD_COUNTER_SATURATE_EN
        checkVal("hex.q", {24'b0, qH}, 32'hFF);
        checkVal("hex.pulses", pulses, 0);
`else
        checkVal("hex.q", {24'b0, qH}, 32'h00);
        checkVal("hex.pulses", pulses, 1);
`endif
        checkVal("hex.ovf", {31'b0, ovfH}, 32'h1);

        // Randomised traffic including back-to-back latches and occasional resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 49) != 0,
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 29) == 0,
                          $urandom_range(0, 5) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
